reg_pipe: RTL
=============

// Module: reg_pipe
// PURPOSE
//  Parametrised multi-stage register pipeline; WIDTH-bit words pass through DEPTH stages.
//  Generalises the fixed 5-bit load register into a registered buffer.
//  Each stage has a valid flag, and stages advance under a valid/ready handshake.
//  Bubbles collapse. Sits between datapath units that can stall each other.
// PARAMETERS
//  WIDTH  5  data word width in bits (>=1)
//  DEPTH  4  number of register stages (>=1); also the buffer capacity in words
// PORTS
//  clk        input   1               rising-edge clock
//  rst        input   1               asynchronous active-low reset
//  flush      input   1               synchronous clear of all stages
//  in_data    input   WIDTH           upstream word
//  in_valid   input   1               upstream word present
//  in_ready   output  1               pipe accepts in_data this cycle
//  out_data   output  WIDTH           word in the last stage
//  out_valid  output  1               last stage holds a valid word
//  out_ready  input   1               downstream accepts out_data this cycle
//  count      output  $clog2(DEPTH+1) occupied stages (only with REG_PIPE_COUNT_EN)
// BEHAVIOUR
//  - Reset (rst=0, async): all stage data=0, all valid=0.
//    Hence out_data=0, out_valid=0, in_ready=1, count=0.
//  - Stage k (0=input side, DEPTH-1=output side) holds data[k] and v[k].
//  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
//  - adv[k] = ~v[k] | adv[k+1] for k<DEPTH-1.
//  - in_ready = adv[0] & ~flush. This path is combinational from out_ready.
//  - Transfer in: in_valid & in_ready.
//  - Transfer out: out_valid & out_ready.
//  - Each clock, if adv[k]:
//    - Stage k loads from stage k-1 (or from the input for k=0), data and valid.
//    - If the source is invalid, v[k] becomes 0 and data[k] holds its old value.
//    - A stage whose adv[k]=0 holds data and valid.
//  - Latency: a word accepted at edge N appears on out_valid after edge N+DEPTH-1 when no stall occurs.
//    Equivalently, DEPTH edges from the in_valid cycle to the out_valid cycle.
//  - Throughput: one word per cycle when out_ready=1 continuously.
//  - Bubble collapse: an invalid stage always advances. A stalled pipe compacts toward the output.
//  - Full: all v=1 and out_ready=0 -> in_ready=0, and no stage changes.
//  - Full with out_ready=1: simultaneous in/out transfer. Occupancy stays DEPTH.
//  - Empty: out_valid=0. out_data holds the last value it had.
//  - flush=1 at an edge: all v cleared, data untouched, and in_ready=0 that cycle.
//    Flush wins over any simultaneous in/out transfer; the word on in_data is not accepted.
//    out_valid may still be 1 during the flush cycle. A downstream out_ready that cycle does not count as a transfer.
//  - Reset asserted mid-transfer aborts immediately. All words are lost.
//  - DEPTH=1: a single register stage, no bypass path.
// CONFIGURATION
//  - REG_PIPE_COUNT_EN defined: port count present.
//    - Registered occupancy counter = number of v[k]=1.
//    - +1 on in-transfer only, -1 on out-transfer only, unchanged on both or neither.
//    - Zeroed on flush and on reset. Never exceeds DEPTH.
//  - REG_PIPE_COUNT_EN undefined: no count port and no counter logic. All other behaviour is identical.
// TESTING
//  1. Reset with rst=0 then release -> out_valid=0, out_data=0, in_ready=1 (count=0 with _EN).
//  2. WIDTH=5, DEPTH=4, out_ready=1; drive 5'h11,12,13 on consecutive cycles.
//     -> out_data 5'h11,12,13 on 3 consecutive cycles, starting 4 cycles after the first in_valid.
//  3. out_ready=0; push 5'h01..5'h04 -> in_ready=0 after the 4th word.
//     5'h05 is not accepted, and count=4 (with _EN).
//     Then out_ready=1 for 4 cycles -> 01,02,03,04 in order.
//  4. Full pipe; in_valid=1 with 5'h1F and out_ready=1 same cycle -> 5'h01 leaves and 5'h1F enters.
//     count stays 4 (with _EN).
//  5. Two words inside; flush=1 together with in_valid=1 and data 5'h0A.
//     -> next cycle out_valid=0, and 5'h0A never appears. count=0 (with _EN).
//  6. Words in flight; pulse rst=0 between clock edges -> out_valid drops immediately.
//     No stale word emerges after release.

Source files
------------

// File: rtl/reg_pipe.sv
// -----------------------------------------------------------------------------
// reg_pipe -- parametrised multi-stage register pipeline with per-stage valid
// flags and a valid/ready handshake. Invalid stages always advance, so bubbles
// collapse and a stalled pipe compacts toward the output. The pipe holds up to
// DEPTH words.
//
// Parameters
//   WIDTH      data word width in bits (>=1)
//   DEPTH      number of register stages (>=1), equal to the capacity in words
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears all data and valid flags)
//   flush      synchronous clear of all valid flags (data left untouched)
//   in_data    upstream word
//   in_valid   upstream word present
//   in_ready   pipe accepts in_data this cycle (combinational from out_ready)
//   out_data   word held in the last stage
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts out_data this cycle
//   count      occupied stages (present only when REG_PIPE_COUNT_EN is defined)
//
// Configuration macro
//   REG_PIPE_COUNT_EN  adds the registered occupancy counter and the count port
// -----------------------------------------------------------------------------
module reg_pipe #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef REG_PIPE_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    // Stage 0 is the input side and stage DEPTH-1 is the output side.
    logic [WIDTH-1:0] stage_data_s [DEPTH];
    logic [DEPTH-1:0] stage_valid_s;
    logic [DEPTH-1:0] adv_s;

    // Advance chain: a stage may load if it is empty or the stage after it
    // advances. Evaluated from the output side back toward the input side.
    always_comb begin
        logic chain_s;
        adv_s   = {DEPTH{1'b0}};
        chain_s = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain_s  = ~stage_valid_s[k] | chain_s;
            adv_s[k] = chain_s;
        end
    end

    // Flush blocks acceptance so a word presented during a flush is dropped.
    assign in_ready  = adv_s[0] & ~flush;
    assign out_data  = stage_data_s[DEPTH-1];
    assign out_valid = stage_valid_s[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] src_data_s;
        logic             src_valid_s;
        logic [WIDTH-1:0] data_r;
        logic             valid_r;

        if (k == 0) begin : g_first
            assign src_data_s  = in_data;
            assign src_valid_s = in_valid;
        end else begin : g_next
            assign src_data_s  = stage_data_s[k-1];
            assign src_valid_s = stage_valid_s[k-1];
        end

        // Stage register: loads from its source when advancing; an invalid
        // source only clears the valid flag so the data keeps its old value.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_r  <= {WIDTH{1'b0}};
                valid_r <= 1'b0;
            end else if (flush) begin
                valid_r <= 1'b0;
            end else if (adv_s[k]) begin
                if (src_valid_s) begin
                    data_r  <= src_data_s;
                    valid_r <= 1'b1;
                end else begin
                    valid_r <= 1'b0;
                end
            end else begin
                valid_r <= valid_r;
            end
        end

        assign stage_data_s[k]  = data_r;
        assign stage_valid_s[k] = valid_r;
    end

`ifdef REG_PIPE_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_xfer_s;
    logic          out_xfer_s;
    logic [CW-1:0] count_r;

    // A flush cancels any transfer in its cycle, so neither side counts then.
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready & ~flush;

    // Occupancy counter tracking the number of set valid flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({in_xfer_s, out_xfer_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
`endif

endmodule
